core_inst_seq: RTL and testbench
================================

# core_inst_seq

Hardware instruction sequencer that generates the 34-bit `inst` word for `core` autonomously, replacing bench-driven sequencing. It walks every kernel position: weight fetch to L0, PE load, activation fetch to L0, execute, OFIFO drain to pmem, then optional pmem accumulation. It is parametrised in array size, tile lengths and memory bases, and adds runtime kij count, weight-reuse and accumulate modes. It sits between a host start/done handshake and `core`.

## Interface
- `ROW`, 8, PE rows; weight-load cycle count base.
- `COL`, 8, PE columns; weight words per kij.
- `LEN_NIJ`, 36, activation words per tile.
- `LEN_ONIJ`, 16, outputs per kij.
- `MAX_KIJ`, 9, maximum kernel positions.
- `GAP`, 10, idle cycles between PE load and activation fetch.
- `W_BASE`, 1024, xmem base address of weights.
- `P_BASE`, 0, pmem base address of psums.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  start request; sampled only in IDLE.
- `num_kij`  in  4  kernel positions to run, 1..MAX_KIJ; latched at start.
- `w_reuse`  in  1  latched at start; 1 = skip weight fetch and PE load for kij>0.
- `acc_en`  in  1  latched at start; 1 = run ACC phase after the last kij.
- `ofifo_valid`  in  1  from `core`.
- `inst`  out  34  to `core`. Bit map: acc[33], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20], CEN_xmem[19], WEN_xmem[18], A_xmem[17:7], ofifo_rd[6], ififo_wr[5], ififo_rd[4], l0_rd[3], l0_wr[2], execute[1], load[0].
- `busy`  out  1  high from the cycle after start acceptance until done.
- `done`  out  1  one-cycle pulse at completion.
- `o_valid`  out  1  one-cycle pulse per accumulated output (ACC phase).
- `err`  out  1  sticky until next start; `num_kij` out of range.

## Operation
- Reset/IDLE value:
  - `inst` = 34'h1_800C_0000 (both CEN/WEN = 1, all else 0).
  - `busy` = 0, `done` = 0, `o_valid` = 0, `err` = 0.
  - The IDLE word is driven in every gap cycle.
- `start` with `num_kij` = 0 or > MAX_KIJ: `err` = 1, no sequence is run, `done` pulses next cycle.
- FSM: IDLE → WFETCH → WLOAD → GAP → XFETCH → EXEC → DRAIN → (next kij: WFETCH, or XFETCH if `w_reuse` and kij>0) → ACC (if `acc_en`) → FIN → IDLE.
- WFETCH, COL+1 cycles:
  - CEN_xmem = 0, WEN_xmem = 1, A_xmem = W_BASE + kij·COL + t for t = 0..COL-1.
  - l0_wr = 1 on cycles 1..COL, one cycle behind the read because of SRAM latency.
- WLOAD: load = l0_rd = 1 for ROW+1 cycles.
- GAP: GAP idle cycles.
- XFETCH: same pattern as WFETCH over addresses 0..LEN_NIJ-1, with LEN_NIJ+1 cycles.
- EXEC: execute = ififo_rd = 1 for LEN_NIJ+1 cycles.
- DRAIN:
  - ofifo_rd = `ofifo_valid` each cycle.
  - Each accepted read writes pmem one cycle later: CEN_pmem = 0, WEN_pmem = 0, A_pmem = P_BASE + kij·LEN_ONIJ + n.
  - Exits after LEN_ONIJ reads.
  - No timeout: the sequencer waits indefinitely for `ofifo_valid`.
- ACC, for o = 0..LEN_ONIJ-1:
  - num_kij read cycles: CEN_pmem = 0, WEN_pmem = 1, A_pmem = P_BASE + k·LEN_ONIJ + o.
  - acc = 1 on read cycles 1..num_kij, i.e. lagging by one.
  - `o_valid` pulses the cycle after the final acc.
  - One idle cycle follows before the next o.
- Address arithmetic is 11-bit and wraps modulo 2048. Overflow is not flagged.
- `start` while busy is ignored.
- Reset mid-operation: returns to IDLE immediately; every output takes its reset value asynchronously.

## Timing
- `start` high in IDLE at edge N: `busy` = 1 and the first WFETCH word are valid after edge N+1.
- All outputs are registered; no combinational path from `ofifo_valid` to `inst`.
- The ofifo_rd decision uses `ofifo_valid` sampled at the same edge, so it is one cycle late relative to a combinational read.
- The `core` side flops `inst` again: total latency from FSM to effect is 2 cycles.
- `done` pulses the cycle FIN is entered. `busy` falls in the same cycle.
- Cycle count with `w_reuse` = 0, `acc_en` = 0, `ofifo_valid` always high:
  - Per kij: (COL+1)+(ROW+1)+GAP+2(LEN_NIJ+1)+LEN_ONIJ+1.
  - Defaults: 9+9+10+74+17 = 119 per kij.

## Structure
- Package `core_pkg`:
  - Bit-position localparams for all 14 inst fields and INST_W = 34.
  - IDLE_INST constant.
  - FSM state enum.
- One sub-module, `xmem_burst`: counter emitting CEN/A_xmem with the one-cycle-lagged l0_wr. Shared by WFETCH and XFETCH.

## Test plan
- Reset, then idle 5 cycles → `inst` = 34'h1_800C_0000, `busy` = 0 throughout.
- `start`, `num_kij` = 1, defaults, `ofifo_valid` tied high → A_xmem 1024..1031 then 0..35, 16 pmem writes at 0..15, `done` at cycle 120.
- `num_kij` = 9, `w_reuse` = 1 → exactly one WFETCH/WLOAD (at kij 0), last pmem write at address 143.
- `ofifo_valid` toggling 1010… during DRAIN → ofifo_rd mirrors it, and exactly 16 writes occur at contiguous addresses.
- `acc_en` = 1, `num_kij` = 9 → for o = 3, reads 3,19,…,131, acc high 9 cycles, 16 `o_valid` pulses.
- `num_kij` = 0 → `err` = 1, `done` pulse, no non-idle `inst`. Reset asserted mid-EXEC → `inst` idle immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: inst field map,
// idle word and sequencer states.
package core_pkg;
    localparam int INST_W     = 34;
    localparam int A_W        = 11;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_A_P      = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_A_X      = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WFETCH = 4'd1,
        S_WLOAD  = 4'd2,
        S_GAP    = 4'd3,
        S_XFETCH = 4'd4,
        S_EXEC   = 4'd5,
        S_DRAIN  = 4'd6,
        S_ACC    = 4'd7,
        S_FIN    = 4'd8
    } state_t;
endpackage

// File: rtl/core_inst_seq_xmem_burst.sv
// Address burst generator for xmem-to-L0 transfers; l0_wr trails each
// read by one cycle to cover the SRAM read latency.
module xmem_burst
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [A_W-1:0] base,
    input  logic [31:0]    len,
    output logic           cen,
    output logic [A_W-1:0] addr,
    output logic           l0_wr,
    output logic           last
);
    logic [31:0] t;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           t <= '0;
        else if (en && !last) t <= t + 1'b1;
        else                  t <= '0;
    end

    assign cen   = !(en && (t < len));
    assign addr  = base + t[A_W-1:0];
    assign l0_wr = en && (t != '0);
    assign last  = en && (t == len);
endmodule

// File: rtl/core_inst_seq.sv
// Autonomous instruction sequencer for core: walks every kernel position
// (weights, activations, execute, drain) and optionally accumulates psums.
module core_inst_seq
    import core_pkg::*;
#(
    parameter int ROW      = 8,
    parameter int COL      = 8,
    parameter int LEN_NIJ  = 36,
    parameter int LEN_ONIJ = 16,
    parameter int MAX_KIJ  = 9,
    parameter int GAP      = 10,
    parameter int W_BASE   = 1024,
    parameter int P_BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        num_kij,
    input  logic              w_reuse,
    input  logic              acc_en,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              o_valid,
    output logic              err
);
    state_t            state, state_n;
    logic [31:0]       cnt, kij, oidx, rd_n, nk32;
    logic [3:0]        nk;
    logic              reuse_q, acc_q, wr_pend, rd, bad_kij, acc_step_end;
    logic [INST_W-1:0] inst_n;
    logic              bx_en, bx_cen, bx_l0_wr, bx_last;
    logic [A_W-1:0]    bx_base, bx_addr;
    logic [31:0]       bx_len;

    assign nk32         = 32'(nk);
    assign bad_kij      = (num_kij == '0) || (32'(num_kij) > MAX_KIJ);
    assign rd           = (state == S_DRAIN) && (rd_n < LEN_ONIJ) && ofifo_valid;
    assign acc_step_end = (state == S_ACC) && (cnt == nk32 + 1);

    assign bx_en   = (state == S_WFETCH) || (state == S_XFETCH);
    assign bx_base = (state == S_WFETCH) ? 11'(W_BASE + kij * COL) : '0;
    assign bx_len  = (state == S_WFETCH) ? 32'(COL) : 32'(LEN_NIJ);

    xmem_burst u_burst (
        .clk   (clk),
        .reset (reset),
        .en    (bx_en),
        .base  (bx_base),
        .len   (bx_len),
        .cen   (bx_cen),
        .addr  (bx_addr),
        .l0_wr (bx_l0_wr),
        .last  (bx_last)
    );

    always_comb begin
        state_n = state;
        inst_n  = IDLE_INST;
        case (state)
            S_IDLE: if (start) state_n = bad_kij ? S_FIN : S_WFETCH;
            S_WFETCH, S_XFETCH: begin
                inst_n[B_CEN_X] = bx_cen;
                if (!bx_cen) inst_n[B_A_X +: A_W] = bx_addr;
                inst_n[B_L0_WR] = bx_l0_wr;
                if (bx_last) state_n = (state == S_WFETCH) ? S_WLOAD : S_EXEC;
            end
            S_WLOAD: begin
                inst_n[B_LOAD]  = 1'b1;
                inst_n[B_L0_RD] = 1'b1;
                if (cnt == ROW) state_n = S_GAP;
            end
            S_GAP: if (cnt == GAP - 1) state_n = S_XFETCH;
            S_EXEC: begin
                inst_n[B_EXEC]     = 1'b1;
                inst_n[B_IFIFO_RD] = 1'b1;
                if (cnt == LEN_NIJ) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                inst_n[B_OFIFO_RD] = rd;
                // rd_n already counts the read being written back this cycle
                if (wr_pend) begin
                    inst_n[B_CEN_P]        = 1'b0;
                    inst_n[B_WEN_P]        = 1'b0;
                    inst_n[B_A_P +: A_W]   = 11'(P_BASE + kij * LEN_ONIJ + rd_n - 1);
                end
                if (wr_pend && (rd_n == LEN_ONIJ)) begin
                    if (kij + 1 < nk32) state_n = reuse_q ? S_XFETCH : S_WFETCH;
                    else                state_n = acc_q ? S_ACC : S_FIN;
                end
            end
            S_ACC: begin
                if (cnt < nk32) begin
                    inst_n[B_CEN_P]      = 1'b0;
                    inst_n[B_A_P +: A_W] = 11'(P_BASE + cnt * LEN_ONIJ + oidx);
                end
                inst_n[B_ACC] = (cnt >= 1) && (cnt <= nk32);
                if (acc_step_end && (oidx == LEN_ONIJ - 1)) state_n = S_FIN;
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            inst    <= IDLE_INST;
            busy    <= 1'b0;
            done    <= 1'b0;
            o_valid <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            kij     <= '0;
            oidx    <= '0;
            rd_n    <= '0;
            wr_pend <= 1'b0;
            nk      <= '0;
            reuse_q <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state   <= state_n;
            inst    <= inst_n;
            busy    <= (state != S_IDLE) && (state != S_FIN);
            done    <= (state == S_FIN);
            o_valid <= acc_step_end;

            if ((state == S_IDLE) && start) begin
                nk      <= num_kij;
                reuse_q <= w_reuse;
                acc_q   <= acc_en;
                err     <= bad_kij;
                kij     <= '0;
            end else if ((state == S_DRAIN) && (state_n != S_DRAIN)) begin
                kij <= kij + 1'b1;
            end

            if (acc_step_end || (state_n != state) || (state == S_IDLE)) cnt <= '0;
            else                                                           cnt <= cnt + 1'b1;

            if (state != S_ACC)    oidx <= '0;
            else if (acc_step_end) oidx <= oidx + 1'b1;

            if (state != S_DRAIN) begin
                rd_n    <= '0;
                wr_pend <= 1'b0;
            end else begin
                rd_n    <= rd_n + 32'(rd);
                wr_pend <= rd;
            end
        end
    end
endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: directed and randomized jobs compared
// against expected address streams and event counts built from the sequencing rules.
`timescale 1ns/1ps
module tb_core_inst_seq;
    localparam int ROW = 8, COL = 8, LEN_NIJ = 36, LEN_ONIJ = 16, MAX_KIJ = 9, GAP = 10;
    localparam int W_BASE = 1024, P_BASE = 0;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic        w_reuse = 1'b0, acc_en = 1'b0, ofifo_valid = 1'b0;
    logic [3:0]  num_kij = 4'd0;
    logic [33:0] inst;
    logic        busy, done, o_valid, err;
    logic        rec = 1'b0;
    int          checks = 0, errors = 0;

    core_inst_seq #(
        .ROW(ROW), .COL(COL), .LEN_NIJ(LEN_NIJ), .LEN_ONIJ(LEN_ONIJ),
        .MAX_KIJ(MAX_KIJ), .GAP(GAP), .W_BASE(W_BASE), .P_BASE(P_BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_kij(num_kij),
        .w_reuse(w_reuse), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .o_valid(o_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Observed activity, gathered each cycle while rec is high.
    int   xq[$], pwq[$], prq[$];
    int   n_l0wr, n_load, n_exec, n_rd, n_acc, n_oval, n_nonidle;
    int   v_pair, v_rd, v_wr, v_l0, v_ov;
    logic p_valid, p_rd, p_xrd, p_acc;

    always @(negedge clk) begin
        if (!rec) begin
            xq.delete(); pwq.delete(); prq.delete();
            n_l0wr <= 0; n_load <= 0; n_exec <= 0; n_rd <= 0; n_acc <= 0; n_oval <= 0;
            n_nonidle <= 0; v_pair <= 0; v_rd <= 0; v_wr <= 0; v_l0 <= 0; v_ov <= 0;
            p_valid <= 1'b0; p_rd <= 1'b0; p_xrd <= 1'b0; p_acc <= 1'b0;
        end else begin
            if (!inst[19]) xq.push_back(int'(inst[17:7]));
            if (!inst[32] && !inst[31]) pwq.push_back(int'(inst[30:20]));
            if (!inst[32] &&  inst[31]) prq.push_back(int'(inst[30:20]));
            n_l0wr    <= n_l0wr + int'(inst[2]);
            n_load    <= n_load + int'(inst[0]);
            n_exec    <= n_exec + int'(inst[1]);
            n_rd      <= n_rd + int'(inst[6]);
            n_acc     <= n_acc + int'(inst[33]);
            n_oval    <= n_oval + int'(o_valid);
            n_nonidle <= n_nonidle + int'(inst !== IDLE_W);
            v_pair    <= v_pair + int'((inst[0] != inst[3]) || (inst[1] != inst[4]) || !inst[18] || inst[5]);
            v_rd      <= v_rd + int'(inst[6] && !p_valid);
            v_wr      <= v_wr + int'(!inst[32] && !inst[31] && !p_rd);
            v_l0      <= v_l0 + int'(inst[2] && !p_xrd);
            v_ov      <= v_ov + int'(o_valid && !p_acc);
            p_valid   <= ofifo_valid;
            p_rd      <= inst[6];
            p_xrd     <= !inst[19];
            p_acc     <= inst[33];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int obs[$], input int exp[$]);
        int bad_i = -1;
        chk({tag, "_count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            if (bad_i < 0 && obs[i] != exp[i]) bad_i = i;
        if (bad_i >= 0)
            $display("  %s first difference at %0d: got %0d want %0d", tag, bad_i, obs[bad_i], exp[bad_i]);
        chk({tag, "_first_diff_idx"}, bad_i, -1);
    endtask

    // vmode: 0 = ofifo_valid always high, 1 = toggling 1010, 2 = random
    task automatic run_job(input string tag, input int nkv, input bit reuse, input bit acc, input int vmode);
        int exq[$], epw[$], epr[$];
        int nwf = 0, exp_cyc = 1, k = 0, busy_lo = 0;
        bit got = 0;
        bit bad = (nkv == 0) || (nkv > MAX_KIJ);
        if (!bad) begin
            for (int kk = 0; kk < nkv; kk++) begin
                if (!reuse || kk == 0) begin
                    nwf++;
                    for (int t = 0; t < COL; t++) exq.push_back((W_BASE + kk * COL + t) % 2048);
                    exp_cyc += (COL + 1) + (ROW + 1) + GAP;
                end
                for (int t = 0; t < LEN_NIJ; t++) exq.push_back(t % 2048);
                for (int n = 0; n < LEN_ONIJ; n++) epw.push_back((P_BASE + kk * LEN_ONIJ + n) % 2048);
                exp_cyc += 2 * (LEN_NIJ + 1) + LEN_ONIJ + 1;
            end
            if (acc) begin
                for (int o = 0; o < LEN_ONIJ; o++)
                    for (int kk = 0; kk < nkv; kk++) epr.push_back((P_BASE + kk * LEN_ONIJ + o) % 2048);
                exp_cyc += LEN_ONIJ * (nkv + 2);
            end
        end
        rec = 1'b0; @(negedge clk); #1; rec = 1'b1;
        @(posedge clk); #2;
        num_kij = 4'(nkv); w_reuse = reuse; acc_en = acc; ofifo_valid = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        while (!got && k < 8000) begin
            @(posedge clk); #2;
            k++;
            if (vmode == 1)      ofifo_valid = logic'(k % 2);
            else if (vmode == 2) ofifo_valid = 1'($urandom_range(0, 1));
            else                 ofifo_valid = 1'b1;
            if (done) got = 1;
            else if (!busy) busy_lo++;
        end
        @(negedge clk); #1;
        chk({tag, " done_seen"}, got, 1);
        if (vmode == 0) chk({tag, " done_cycle"}, k, exp_cyc);
        chk({tag, " busy_low_while_running"}, busy_lo, 0);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " err"}, err, bad);
        cmp_q({tag, " xmem_addr"}, xq, exq);
        cmp_q({tag, " pmem_wr_addr"}, pwq, epw);
        cmp_q({tag, " pmem_rd_addr"}, prq, epr);
        chk({tag, " l0_wr_cycles"}, n_l0wr, bad ? 0 : nwf * COL + nkv * LEN_NIJ);
        chk({tag, " load_cycles"}, n_load, nwf * (ROW + 1));
        chk({tag, " exec_cycles"}, n_exec, bad ? 0 : nkv * (LEN_NIJ + 1));
        chk({tag, " ofifo_rd_cycles"}, n_rd, bad ? 0 : nkv * LEN_ONIJ);
        chk({tag, " acc_cycles"}, n_acc, (!bad && acc) ? nkv * LEN_ONIJ : 0);
        chk({tag, " o_valid_pulses"}, n_oval, (!bad && acc) ? LEN_ONIJ : 0);
        chk({tag, " field_pairing"}, v_pair, 0);
        chk({tag, " ofifo_rd_without_valid"}, v_rd, 0);
        chk({tag, " pmem_wr_not_after_rd"}, v_wr, 0);
        chk({tag, " l0_wr_not_after_read"}, v_l0, 0);
        chk({tag, " o_valid_not_after_acc"}, v_ov, 0);
        if (bad) chk({tag, " nonidle_inst"}, n_nonidle, 0);
    endtask

    initial begin
        int k;
        int nkv;
        bit rr, aa;

        #12;
        chk("reset_inst", inst, IDLE_W);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_o_valid", o_valid, 0);
        chk("reset_err", err, 0);
        @(negedge clk); reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_inst", inst, IDLE_W);
            chk("idle_busy", busy, 0);
        end

        run_job("kij1", 1, 0, 0, 0);
        run_job("kij9_reuse", 9, 1, 0, 0);
        chk("kij9_reuse last_pmem_wr", (pwq.size() > 0) ? pwq[pwq.size()-1] : -1, 143);
        run_job("drain_toggle", 1, 0, 0, 1);
        run_job("acc_kij9", 9, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            nkv = $urandom_range(1, MAX_KIJ);
            rr  = 1'($urandom_range(0, 1));
            aa  = 1'($urandom_range(0, 1));
            run_job($sformatf("rand%0d_k%0d_r%0d_a%0d", i, nkv, rr, aa), nkv, rr, aa, 2);
        end
        run_job("kij0_err", 0, 0, 0, 0);
        run_job("kij10_err", 10, 1, 1, 0);

        // Reset pulled while the array is executing
        rec = 1'b0;
        @(posedge clk); #2;
        num_kij = 4'd2; w_reuse = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        k = 0;
        while (!inst[1] && k < 500) begin
            @(posedge clk); #2;
            k++;
        end
        chk("midexec reached_exec", inst[1], 1);
        chk("midexec err_cleared_by_start", err, 0);
        chk("midexec busy", busy, 1);
        #3 reset = 1'b0;
        #1;
        chk("midexec reset_inst", inst, IDLE_W);
        chk("midexec reset_busy", busy, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        run_job("after_reset", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
